alu_protocol_monitor: RTL and testbench

- Synthesizable, parametrised successor to the ALU assertion/coverage interface.
- Passively snoops the ALU input bus and result, tracks each operation through a small FSM, and checks four protocol rules:
  - second-operand arrival within a programmable window;
  - cmd/mode stability while an operation is pending;
  - multiply-latency stability;
  - result hold while ce is low.
- Reports single-cycle error pulses, sticky flags and saturating per-rule counters.
- Sits beside the ALU in both the UVM bench and the FPGA build. It has no effect on DUT behaviour.

---
 rtl/alu_protocol_monitor.sv | 177 +++++++++++++++++
 tb/tb_alu_protocol_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_protocol_monitor.sv
// Passive ALU protocol monitor: follows each operation through IDLE/WAIT/MUL and flags
// operand timeouts, cmd/mode changes while pending, multiply aborts and result-hold violations.
module alu_protocol_monitor #(
    parameter int DWIDTH    = 8,
    parameter int CWIDTH    = 4,
    parameter int TIMEOUT   = 16,
    parameter int MUL_LAT   = 2,
    parameter int CNT_WIDTH = 8,
    parameter logic [(1<<CWIDTH)-1:0] ARITH2_MASK = 16'h010F,
    parameter logic [(1<<CWIDTH)-1:0] MUL_MASK    = 16'h0600,
    parameter logic [(1<<CWIDTH)-1:0] LOGIC2_MASK = 16'h303F
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   mode,
    input  logic [CWIDTH-1:0]      cmd,
    input  logic [1:0]             inp_valid,
    input  logic [DWIDTH:0]        res,
    input  logic                   clr_err,
    output logic                   busy,
    output logic                   op_done,
    output logic [$clog2(TIMEOUT+1)-1:0] wait_cycles,
    output logic [3:0]             err_pulse,
    output logic [3:0]             err_sticky,
    output logic [4*CNT_WIDTH-1:0] err_cnt
);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam int MW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT+1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL} state_t;

    state_t              state, state_n;
    logic [CWIDTH-1:0]   cmd_l, cmd_n;
    logic                mode_l, mode_n;
    logic [1:0]          seen_l, seen_n;
    logic [TW-1:0]       timer, timer_n, t_inc;
    logic [TW-1:0]       wait_l, wait_l_n, done_wait;
    logic [MW-1:0]       mul_cnt, mul_n, mul_dec;
    logic                done;
    logic [2:0]          err_det;
    logic                is_two, is_mul, is_mul_l, cmd_chg, arrive, hold_det;
    logic                ce_d;
    logic [DWIDTH:0]     res_d;
    logic [CNT_WIDTH-1:0] cnt [4];

    // inp_valid bits are per-operand "present this cycle" flags; there is no ready, the
    // monitor only observes, so a bit counts the first time it is seen while pending.
    assign is_mul   = mode & MUL_MASK[cmd];
    assign is_two   = (mode & ARITH2_MASK[cmd]) | (!mode & LOGIC2_MASK[cmd]) | is_mul;
    assign is_mul_l = mode_l & MUL_MASK[cmd_l];
    assign cmd_chg  = (cmd != cmd_l) || (mode != mode_l);
    assign arrive   = |(inp_valid & ~seen_l);
    assign t_inc    = timer + 1'b1;
    assign mul_dec  = mul_cnt - 1'b1;
    assign hold_det = !ce_d && (res != res_d);

    always_comb begin
        state_n   = state;
        cmd_n     = cmd_l;
        mode_n    = mode_l;
        seen_n    = seen_l;
        timer_n   = timer;
        mul_n     = mul_cnt;
        wait_l_n  = wait_l;
        done      = 1'b0;
        done_wait = wait_l;
        err_det   = 3'b000;
        if (ce) begin
            case (state)
                S_IDLE: begin
                    if (inp_valid != 2'b00) begin
                        if (!is_two || inp_valid == 2'b11) begin
                            if (is_mul && MUL_LAT > 0) begin
                                state_n  = S_MUL;
                                mul_n    = MW'(MUL_LAT);
                                cmd_n    = cmd;
                                mode_n   = mode;
                                wait_l_n = '0;
                            end else begin
                                done      = 1'b1;
                                done_wait = '0;
                            end
                        end else begin
                            state_n = S_WAIT;
                            cmd_n   = cmd;
                            mode_n  = mode;
                            seen_n  = inp_valid;
                            timer_n = '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cmd_chg) begin
                        err_det[1] = 1'b1;
                        state_n    = S_IDLE;
                    end else if (arrive) begin
                        if (is_mul_l && MUL_LAT > 0) begin
                            state_n  = S_MUL;
                            mul_n    = MW'(MUL_LAT);
                            wait_l_n = t_inc;
                        end else begin
                            state_n   = S_IDLE;
                            done      = 1'b1;
                            done_wait = t_inc;
                        end
                    end else if (t_inc >= TW'(TIMEOUT)) begin
                        err_det[0] = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        timer_n = t_inc;
                    end
                end
                S_MUL: begin
                    if (cmd_chg) begin
                        err_det[2] = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        mul_n = mul_dec;
                        if (mul_dec == '0) begin
                            state_n = S_IDLE;
                            done    = 1'b1;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cmd_l       <= '0;
            mode_l      <= 1'b0;
            seen_l      <= 2'b00;
            timer       <= '0;
            mul_cnt     <= '0;
            wait_l      <= '0;
            op_done     <= 1'b0;
            wait_cycles <= '0;
            err_pulse   <= 4'b0000;
            err_sticky  <= 4'b0000;
            // ce_d=1 keeps the first cycle after reset from comparing against a stale res.
            ce_d        <= 1'b1;
            res_d       <= res;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            state     <= state_n;
            cmd_l     <= cmd_n;
            mode_l    <= mode_n;
            seen_l    <= seen_n;
            timer     <= timer_n;
            mul_cnt   <= mul_n;
            wait_l    <= wait_l_n;
            op_done   <= done;
            if (done) wait_cycles <= done_wait;
            err_pulse <= {hold_det, err_det};
            ce_d      <= ce;
            res_d     <= res;
            err_sticky <= clr_err ? err_pulse : (err_sticky | err_pulse);
            for (int i = 0; i < 4; i++) begin
                if (err_pulse[i])
                    cnt[i] <= clr_err ? CNT_WIDTH'(1) : ((cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 1'b1);
                else if (clr_err)
                    cnt[i] <= '0;
            end
        end
    end

    assign busy = (state != S_IDLE);

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign err_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end
endmodule

// File: tb/tb_alu_protocol_monitor.sv
// Directed bench for alu_protocol_monitor: one task per scenario, hand-computed expectations.
module tb_alu_protocol_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        mode;
    logic [3:0]  cmd;
    logic [1:0]  inp_valid;
    logic [8:0]  res;
    logic        clr_err;
    logic        busy;
    logic        op_done;
    logic [4:0]  wait_cycles;
    logic [3:0]  err_pulse;
    logic [3:0]  err_sticky;
    logic [31:0] err_cnt;

    int errors = 0;
    int checks = 0;

    alu_protocol_monitor dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
        .res(res), .clr_err(clr_err), .busy(busy), .op_done(op_done),
        .wait_cycles(wait_cycles), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic m, input logic [3:0] k, input logic [1:0] v);
        ce = c; mode = m; cmd = k; inp_valid = v;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0; ce = 1'b1; mode = 1'b0; cmd = 4'd0; inp_valid = 2'b00; clr_err = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL rst_op_done: got %0b want 0", op_done); end
        checks++; if (wait_cycles !== 5'd0) begin errors++; $display("FAIL rst_wait: got %0d want 0", wait_cycles); end
        checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL rst_pulse: got %0h want 0", err_pulse); end
        checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL rst_sticky: got %0h want 0", err_sticky); end
        checks++; if (err_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %0h want 0", err_cnt); end
        drive(1'b1, 1'b1, 4'd0, 2'b11);
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL first_op_done: got %0b want 1", op_done); end
        checks++; if (wait_cycles !== 5'd0) begin errors++; $display("FAIL first_wait: got %0d want 0", wait_cycles); end
        checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL first_sticky: got %0h want 0", err_sticky); end
        drive(1'b1, 1'b1, 4'd0, 2'b00);
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %0b want 0", op_done); end
    endtask

    task automatic test_late_operand();
        do_reset();
        drive(1'b1, 1'b1, 4'd0, 2'b01);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL late_busy: got %0b want 1", busy); end
        repeat (15) drive(1'b1, 1'b1, 4'd0, 2'b00);
        drive(1'b1, 1'b1, 4'd0, 2'b10);
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL late16_done: got %0b want 1", op_done); end
        checks++; if (wait_cycles !== 5'd16) begin errors++; $display("FAIL late16_wait: got %0d want 16", wait_cycles); end
        checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL late16_pulse: got %0h want 0", err_pulse); end
        drive(1'b1, 1'b1, 4'd0, 2'b01);
        repeat (16) drive(1'b1, 1'b1, 4'd0, 2'b00);
        checks++; if (err_pulse !== 4'b0001) begin errors++; $display("FAIL timeout_pulse: got %0h want 1", err_pulse); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %0b want 0", busy); end
        drive(1'b1, 1'b1, 4'd0, 2'b10);
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL late17_done: got %0b want 0", op_done); end
        checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL timeout_pulse_width: got %0h want 0", err_pulse); end
        checks++; if (err_cnt !== 32'h1) begin errors++; $display("FAIL timeout_cnt: got %0h want 1", err_cnt); end
        checks++; if (err_sticky !== 4'b0001) begin errors++; $display("FAIL timeout_sticky: got %0h want 1", err_sticky); end
    endtask

    task automatic test_cmd_change();
        do_reset();
        drive(1'b1, 1'b0, 4'd12, 2'b10);
        drive(1'b1, 1'b0, 4'd12, 2'b00);
        drive(1'b1, 1'b0, 4'd12, 2'b00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy_wait: got %0b want 1", busy); end
        drive(1'b1, 1'b0, 4'd13, 2'b00);
        checks++; if (err_pulse !== 4'b0010) begin errors++; $display("FAIL chg_pulse: got %0h want 2", err_pulse); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_busy: got %0b want 0", busy); end
        drive(1'b1, 1'b0, 4'd13, 2'b00);
        checks++; if (err_sticky !== 4'b0010) begin errors++; $display("FAIL chg_sticky: got %0h want 2", err_sticky); end
        checks++; if (err_cnt !== 32'h0000_0100) begin errors++; $display("FAIL chg_cnt: got %0h want 100", err_cnt); end
    endtask

    task automatic test_multiply();
        do_reset();
        drive(1'b1, 1'b1, 4'd10, 2'b11);
        checks++; if (op_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mul_c1: got done=%0b busy=%0b want 0/1", op_done, busy); end
        drive(1'b1, 1'b1, 4'd10, 2'b00);
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL mul_c2: got %0b want 0", op_done); end
        drive(1'b1, 1'b1, 4'd10, 2'b00);
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL mul_done: got %0b want 1", op_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy: got %0b want 0", busy); end
        drive(1'b1, 1'b1, 4'd10, 2'b11);
        drive(1'b1, 1'b1, 4'd9, 2'b00);
        checks++; if (err_pulse !== 4'b0100) begin errors++; $display("FAIL mul_abort_pulse: got %0h want 4", err_pulse); end
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL mul_abort_done: got %0b want 0", op_done); end
        drive(1'b1, 1'b1, 4'd9, 2'b00);
        checks++; if (op_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_abort_after: got done=%0b busy=%0b want 0/0", op_done, busy); end
        checks++; if (err_cnt !== 32'h0001_0000) begin errors++; $display("FAIL mul_cnt: got %0h want 10000", err_cnt); end
    endtask

    task automatic test_hold_ce();
        logic bad;
        do_reset();
        bad = 1'b0;
        repeat (4) begin
            drive(1'b0, 1'b0, 4'd0, 2'b00);
            if (err_pulse !== 4'h0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_const: got err=%0b want 0", bad); end
        res = 9'h055;
        drive(1'b0, 1'b0, 4'd0, 2'b00);
        checks++; if (err_pulse !== 4'b1000) begin errors++; $display("FAIL hold_pulse: got %0h want 8", err_pulse); end
        drive(1'b1, 1'b0, 4'd0, 2'b00);
        checks++; if (err_sticky !== 4'b1000) begin errors++; $display("FAIL hold_sticky: got %0h want 8", err_sticky); end
        checks++; if (err_cnt !== 32'h0100_0000) begin errors++; $display("FAIL hold_cnt: got %0h want 1000000", err_cnt); end
        do_reset();
        drive(1'b1, 1'b1, 4'd0, 2'b01);
        bad = 1'b0;
        repeat (30) begin
            drive(1'b0, 1'b1, 4'd0, 2'b00);
            if (err_pulse !== 4'h0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ce_freeze: got err=%0b want 0", bad); end
        drive(1'b1, 1'b1, 4'd0, 2'b10);
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL ce_freeze_done: got %0b want 1", op_done); end
        checks++; if (wait_cycles !== 5'd1) begin errors++; $display("FAIL ce_freeze_wait: got %0d want 1", wait_cycles); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b1, 4'd1, 2'b11);
        drive(1'b1, 1'b1, 4'd1, 2'b11);
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b want 1", op_done); end
        drive(1'b1, 1'b0, 4'd6, 2'b01);
        checks++; if (op_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_op: got done=%0b busy=%0b want 1/0", op_done, busy); end
        drive(1'b1, 1'b0, 4'd0, 2'b10);
        checks++; if (op_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL logic_wait: got done=%0b busy=%0b want 0/1", op_done, busy); end
        drive(1'b1, 1'b0, 4'd0, 2'b01);
        checks++; if (op_done !== 1'b1 || wait_cycles !== 5'd1) begin errors++; $display("FAIL logic_done: got done=%0b wait=%0d want 1/1", op_done, wait_cycles); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 1'b1, 4'd0, 2'b01);
            repeat (16) drive(1'b1, 1'b1, 4'd0, 2'b00);
        end
        drive(1'b1, 1'b1, 4'd0, 2'b00);
        drive(1'b1, 1'b1, 4'd0, 2'b00);
        checks++; if (err_cnt !== 32'h0000_00FF) begin errors++; $display("FAIL sat_cnt: got %0h want ff", err_cnt); end
        checks++; if (err_sticky !== 4'b0001) begin errors++; $display("FAIL sat_sticky: got %0h want 1", err_sticky); end
        clr_err = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 2'b00);
        clr_err = 1'b0;
        checks++; if (err_cnt !== 32'h0 || err_sticky !== 4'h0) begin errors++; $display("FAIL clr: got cnt=%0h sticky=%0h want 0/0", err_cnt, err_sticky); end
        drive(1'b1, 1'b1, 4'd0, 2'b01);
        repeat (16) drive(1'b1, 1'b1, 4'd0, 2'b00);
        checks++; if (err_pulse !== 4'b0001) begin errors++; $display("FAIL clr_tmo_pulse: got %0h want 1", err_pulse); end
        clr_err = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 2'b00);
        clr_err = 1'b0;
        checks++; if (err_cnt !== 32'h1) begin errors++; $display("FAIL clr_coincident_cnt: got %0h want 1", err_cnt); end
        checks++; if (err_sticky !== 4'b0001) begin errors++; $display("FAIL clr_coincident_sticky: got %0h want 1", err_sticky); end
        drive(1'b1, 1'b1, 4'd0, 2'b00);
        checks++; if (err_cnt !== 32'h1) begin errors++; $display("FAIL clr_hold_cnt: got %0h want 1", err_cnt); end
    endtask

    initial begin
        rst = 1'b0; ce = 1'b1; mode = 1'b0; cmd = 4'd0; inp_valid = 2'b00;
        res = 9'h0AA; clr_err = 1'b0;
        test_reset();
        test_late_operand();
        test_cmd_change();
        test_multiply();
        test_hold_ce();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
